// File: rtl/bus_xfer_seq.sv
// bus_xfer_seq
// ------------
// Register-transfer sequencer for the 8-bit datapath. It accepts one
// transfer command at a time and generates the per-register strobes that
// the general-purpose registers and the ALU consume.
//
// Command types:
//   MOV (op_i=0): the source register drives the bus and the destination
//                 register loads it.
//   ALU (op_i=1): src drives lhs, src2 drives rhs, the ALU drives its
//                 result onto the bus and the destination register loads it.
//
// Each command runs IDLE -> DRIVE -> LATCH -> RELEASE. The bus drive is up
// one cycle before load_bus and is held for the cycle load_bus is high,
// which gives the registers both setup and hold margin on the load edge.
//
// Optional feature (compile-time macro XFER_CONTENTION_CHECK_EN):
//   bus_en_fb_i is compared against the expected bus drivers in DRIVE and
//   LATCH. A mismatch in DRIVE aborts the command before load_bus rises; a
//   mismatch in LATCH lets the load finish but still flags err_o. Without
//   the macro bus_en_fb_i is ignored and err_o only reports bad indices.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_n_i      asynchronous active-low reset
//   start_i        command request, sampled only while ready_o=1
//   op_i           0 = MOV, 1 = ALU
//   src_i          source / ALU lhs register index
//   src2_i         ALU rhs register index (ignored for MOV)
//   dst_i          destination register index
//   bus_en_fb_i    OR-collected bus_en feedback from the registers
//   assert_bus_o   one-hot register bus-drive strobe
//   assert_lhs_o   one-hot lhs operand strobe
//   assert_rhs_o   one-hot rhs operand strobe
//   assert_alu_o   ALU drives its result onto the bus
//   load_bus_o     one-hot register load strobe
//   ready_o        sequencer can accept start_i this cycle
//   done_o         one-cycle completion pulse (success or error)
//   err_o          one-cycle error pulse, coincident with done_o

module bus_xfer_seq #(
    parameter int NREG = 4
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            start_i,
    input  logic            op_i,
    input  logic [2:0]      src_i,
    input  logic [2:0]      src2_i,
    input  logic [2:0]      dst_i,
    input  logic [NREG-1:0] bus_en_fb_i,
    output logic [NREG-1:0] assert_bus_o,
    output logic [NREG-1:0] assert_lhs_o,
    output logic [NREG-1:0] assert_rhs_o,
    output logic            assert_alu_o,
    output logic [NREG-1:0] load_bus_o,
    output logic            ready_o,
    output logic            done_o,
    output logic            err_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        LATCH   = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            op_q, op_d;
    logic [2:0]      src_q, src_d;
    logic [2:0]      src2_q, src2_d;
    logic [2:0]      dst_q, dst_d;

    logic [NREG-1:0] bus_q, bus_d;
    logic [NREG-1:0] lhs_q, lhs_d;
    logic [NREG-1:0] rhs_q, rhs_d;
    logic            alu_q, alu_d;
    logic [NREG-1:0] load_q, load_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            cmdValid;
    logic            fbMismatch;

    // Out-of-range indices decode to all-zero, so a bad index can never
    // raise a strobe even if it slipped past the validity check.
    function automatic logic [NREG-1:0] oneHot(input logic [2:0] idx);
        logic [NREG-1:0] vec;
        vec = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == i[2:0]) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

    // src2 only matters for ALU commands.
    assign cmdValid = (int'(src_i) < NREG) && (int'(dst_i) < NREG) &&
                      (!op_i || (int'(src2_i) < NREG));

`ifdef XFER_CONTENTION_CHECK_EN
    // The registered bus strobe is already the expected driver set: the
    // source one-hot for MOV, all-zero for ALU (the ALU is not a register).
    assign fbMismatch = (bus_en_fb_i != bus_q);
`else
    logic unusedFb;
    assign unusedFb   = ^bus_en_fb_i;
    assign fbMismatch = 1'b0;
`endif

    // Next state, command capture, and the registered-output values. The
    // strobes are decoded from the next state so that they leave a flop
    // and are glitch-free at the register file.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        src2_d  = src2_q;
        dst_d   = dst_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE, RELEASE: begin
                if (start_i) begin
                    op_d   = op_i;
                    src_d  = src_i;
                    src2_d = src2_i;
                    dst_d  = dst_i;
                    if (cmdValid) begin
                        state_d = DRIVE;
                    end else begin
                        state_d = RELEASE;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DRIVE: begin
                if (fbMismatch) begin
                    state_d = RELEASE;
                    err_d   = 1'b1;
                end else begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                state_d = RELEASE;
                err_d   = fbMismatch;
            end
            default: state_d = IDLE;
        endcase

        bus_d   = '0;
        lhs_d   = '0;
        rhs_d   = '0;
        alu_d   = 1'b0;
        load_d  = '0;
        ready_d = (state_d == IDLE) || (state_d == RELEASE);
        done_d  = (state_d == RELEASE);

        if ((state_d == DRIVE) || (state_d == LATCH)) begin
            if (!op_d) begin
                bus_d = oneHot(src_d);
            end else begin
                lhs_d = oneHot(src_d);
                rhs_d = oneHot(src2_d);
                alu_d = 1'b1;
            end
        end
        if (state_d == LATCH) begin
            load_d = oneHot(dst_d);
        end
    end

    // State and output registers; reset clears load_bus without waiting
    // for a clock edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            src_q   <= '0;
            src2_q  <= '0;
            dst_q   <= '0;
            bus_q   <= '0;
            lhs_q   <= '0;
            rhs_q   <= '0;
            alu_q   <= 1'b0;
            load_q  <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            src2_q  <= src2_d;
            dst_q   <= dst_d;
            bus_q   <= bus_d;
            lhs_q   <= lhs_d;
            rhs_q   <= rhs_d;
            alu_q   <= alu_d;
            load_q  <= load_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign assert_bus_o = bus_q;
    assign assert_lhs_o = lhs_q;
    assign assert_rhs_o = rhs_q;
    assign assert_alu_o = alu_q;
    assign load_bus_o   = load_q;
    assign ready_o      = ready_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: doc/bus_xfer_seq.md
# bus_xfer_seq

Register-transfer sequencer for the 8-bit datapath. It accepts one transfer command at a time and issues the per-register `assert_bus` / `assert_lhs` / `assert_rhs` / `load_bus` strobes that the general-purpose registers consume. Two command types are supported: register-to-register moves over the shared bus, and ALU operations whose result is written back through the bus. It is the initiator side of the register strobe interface and sits between the instruction decoder and the register file / ALU.

## Interface
- `NREG`, default 4: number of general-purpose registers on the bus (2..8).
- `clk` input 1: system clock; all state changes on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: command request, sampled only when `ready`=1.
- `op` input 1: 0 = MOV (src→dst over bus), 1 = ALU (lhs=src, rhs=src2, ALU result→dst).
- `src` input 3: source / ALU lhs register index.
- `src2` input 3: ALU rhs register index; ignored for MOV.
- `dst` input 3: destination register index.
- `bus_en_fb` input NREG: OR-collected `bus_en` feedback from the registers.
- `assert_bus` output NREG: one-hot register bus-drive strobe.
- `assert_lhs` output NREG: one-hot lhs operand strobe.
- `assert_rhs` output NREG: one-hot rhs operand strobe.
- `assert_alu` output 1: ALU drives its result onto the bus.
- `load_bus` output NREG: one-hot register load strobe; the register captures on its rising edge.
- `ready` output 1: sequencer can accept `start` this cycle.
- `done` output 1: one-cycle pulse when a command completes (success or error).
- `err` output 1: one-cycle pulse, coincident with `done`, for a failed command.

## Operation
- States: IDLE, DRIVE, LATCH, RELEASE. Command fields are registered on acceptance and held until RELEASE.
- IDLE: all strobes 0, `ready`=1. `start`=1 moves the FSM to DRIVE, or to RELEASE with error if any used index is ≥ NREG.
- DRIVE:
  - MOV: `assert_bus[src]`=1.
  - ALU: `assert_lhs[src]`=1, `assert_rhs[src2]`=1, `assert_alu`=1.
- LATCH: same drives as DRIVE, plus `load_bus[dst]`=1.
- RELEASE:
  - All strobes 0, `done`=1, `ready`=1.
  - `start`=1 goes back to DRIVE (back-to-back); otherwise the FSM returns to IDLE.
- Strobes are registered outputs, glitch-free, and at most one bit is high per strobe vector.
- MOV with src==dst is legal and executes normally.
- ALU with src==src2 is legal; the same register asserts both lhs and rhs.
- `start` while `ready`=0 is ignored, not queued.
- Reset, including mid-command: the FSM goes to IDLE, all strobes go to 0, `done`=`err`=0, `ready`=1. `load_bus` must drop without a new rising edge.

## Timing
- Reset values: `assert_bus`=`assert_lhs`=`assert_rhs`=`load_bus`=0, `assert_alu`=0, `ready`=1, `done`=0, `err`=0.
- Accept edge = T0. DRIVE runs in T0..T1, LATCH in T1..T2, and RELEASE/`done` in T2..T3.
- Latency from accept to `done` is 3 cycles. Back-to-back throughput is 1 command per 3 cycles.
- Bus drive asserts one cycle before `load_bus` rises and is held one cycle while `load_bus` is high, giving setup margin and hold margin.
- An invalid index goes directly to RELEASE on the accept edge, with `done`+`err` in T0..T1 and no strobes asserted.

## Configuration
- `XFER_CONTENTION_CHECK_EN` defined:
  - In DRIVE, `bus_en_fb` must equal the expected one-hot: `assert_bus` for MOV, all-zero for ALU.
  - On mismatch, the FSM skips LATCH and goes to RELEASE with `err`=1, so `load_bus` never rises.
  - LATCH also checks; a mismatch there still completes the load but flags `err`.
- Not defined: `bus_en_fb` is ignored and `err` fires only for invalid indices.

## Test plan
- Reset with `reset_n`=0 then 1 -> all strobes 0, `ready`=1, `done`=0.
- MOV src=1 dst=3 -> `assert_bus`=0010 for 2 cycles, `load_bus`=1000 in the second cycle only, `done` 3 cycles after accept, `err`=0.
- ALU src=0 src2=2 dst=1 -> `assert_lhs`=0001, `assert_rhs`=0100, `assert_alu`=1 for 2 cycles, `load_bus`=0010 in the second cycle.
- Back-to-back: second `start` held high during RELEASE -> DRIVE of the second command on the next cycle, `done` pulses 3 cycles apart. A `start` pulse during DRIVE is ignored.
- NREG=4, dst=5 -> `done`=`err`=1 one cycle after accept, no strobe ever high. Then `reset_n` pulsed low during LATCH of a valid MOV -> `load_bus` drops to 0 immediately and the FSM returns to IDLE.
- With `XFER_CONTENTION_CHECK_EN`, MOV src=2 while `bus_en_fb`=0110 -> `err`=1, `load_bus` stays 0, `done` 2 cycles after accept. Without the macro -> normal completion, `err`=0.
